// File: rtl/glb_pcfg_responder.sv
// Target-side endpoint of the GLB parallel-configuration bus.
// Ports: clk, reset_n; per-column cgra_cfg_wr_en/rd_en/addr/data and
// cfg_tile_id in; cgra_cfg_rd_data/rd_data_valid, wr_cnt, err out;
// err_clr in. Every column is an independent lane with its own bank.
module glb_pcfg_responder #(
    parameter int CGRA_PER_GLB        = 4,
    parameter int CGRA_CFG_ADDR_WIDTH = 32,
    parameter int CGRA_CFG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH      = 6,
    parameter int CNT_WIDTH           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [CGRA_PER_GLB-1:0] cgra_cfg_wr_en,
    input  logic [CGRA_PER_GLB-1:0] cgra_cfg_rd_en,
    input  logic [CGRA_PER_GLB-1:0][CGRA_CFG_ADDR_WIDTH-1:0] cgra_cfg_addr,
    input  logic [CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_data,
    input  logic [CGRA_PER_GLB-1:0][CGRA_CFG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0]
                 cfg_tile_id,
    output logic [CGRA_PER_GLB-1:0][CGRA_CFG_DATA_WIDTH-1:0] cgra_cfg_rd_data,
    output logic [CGRA_PER_GLB-1:0] cgra_cfg_rd_data_valid,
    output logic [CGRA_PER_GLB-1:0][CNT_WIDTH-1:0] wr_cnt,
    output logic [CGRA_PER_GLB-1:0] err,
    input  logic [CGRA_PER_GLB-1:0] err_clr
);

    localparam int AW    = CGRA_CFG_ADDR_WIDTH;
    localparam int DW    = CGRA_CFG_DATA_WIDTH;
    localparam int RA    = REG_ADDR_WIDTH;
    localparam int DEPTH = 2 ** RA;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic          hit;
        logic [RA-1:0] idx;
        logic [DW-1:0] data;
    } req_t;

    for (genvar c = 0; c < CGRA_PER_GLB; c++) begin : g_col
        req_t           s1;
        logic           hit;
        logic [DW-1:0]  bank [DEPTH];
        logic [DW-1:0]  rd_q;
        logic           vld_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic           err_q;

        assign hit = (cgra_cfg_addr[c][AW-1:RA] == cfg_tile_id[c]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1 <= '0;
            end else begin
                s1.wr   <= cgra_cfg_wr_en[c];
                s1.rd   <= cgra_cfg_rd_en[c];
                s1.hit  <= hit;
                s1.idx  <= cgra_cfg_addr[c][RA-1:0];
                s1.data <= cgra_cfg_data[c];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank[i] <= '0;
                end
            end else if (s1.wr && s1.hit) begin
                bank[s1.idx] <= s1.data;
            end
        end

        // The read samples the bank before this edge's write lands,
        // so a same-cycle wr+rd returns the old entry.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= s1.rd;
                if (s1.rd) begin
                    rd_q <= s1.hit ? bank[s1.idx] : '0;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else if (s1.wr && s1.hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // A new collision beats a coincident clear.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                err_q <= 1'b0;
            end else if (s1.wr && s1.rd) begin
                err_q <= 1'b1;
            end else if (err_clr[c]) begin
                err_q <= 1'b0;
            end
        end

        assign cgra_cfg_rd_data[c]       = rd_q;
        assign cgra_cfg_rd_data_valid[c] = vld_q;
        assign wr_cnt[c]                 = cnt_q;
        assign err[c]                    = err_q;
    end

endmodule
